// File: rtl/dmem_arbiter.sv
// Two-port (CPU / I/O) arbiter in front of a single-port synchronous-read data RAM.
// CPU wins contested cycles, but a bounded CPU burst guarantees I/O forward progress.
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MAX_CPU_BURST = 4
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  cpu_req,
  input  logic                  cpu_wren,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_q,

  input  logic                  io_req,
  input  logic                  io_wren,
  input  logic [ADDR_WIDTH-1:0] io_addr,
  input  logic [DATA_WIDTH-1:0] io_data,
  output logic                  io_gnt,
  output logic                  io_rvalid,
  output logic [DATA_WIDTH-1:0] io_q,

  output logic                  ram_wEn,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_dataIn,
  input  logic [DATA_WIDTH-1:0] ram_dataOut
);

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnCpu  = 2'd1,
    OwnIo   = 2'd2
  } owner_e;

  localparam logic [3:0] MaxBurst = 4'(MAX_CPU_BURST);

  owner_e                  owner_q, owner_d;
  logic [3:0]              burst_cnt_q, burst_cnt_d;
  logic [DATA_WIDTH-1:0]   cpu_hold_q, io_hold_q;
  logic                    contested;

  // Grant decision; held off while reset is asserted so nothing reaches the RAM.
  always_comb begin
    contested = cpu_req & io_req;
    cpu_gnt   = 1'b0;
    io_gnt    = 1'b0;
    if (reset) begin
      if (cpu_req && (!io_req || (burst_cnt_q != MaxBurst))) begin
        cpu_gnt = 1'b1;
      end else if (io_req) begin
        io_gnt = 1'b1;
      end
    end
  end

  // RAM request mux; the CPU port is the idle default.
  always_comb begin
    if (io_gnt) begin
      ram_addr   = io_addr;
      ram_dataIn = io_data;
    end else begin
      ram_addr   = cpu_addr;
      ram_dataIn = cpu_data;
    end
    ram_wEn = (cpu_gnt & cpu_wren) | (io_gnt & io_wren);
  end

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (!io_req || io_gnt) begin
      burst_cnt_d = 4'd0;
    end else if (contested && cpu_gnt) begin
      burst_cnt_d = burst_cnt_q + 4'd1;
    end
  end

  // Read-owner tag: state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_q <= OwnNone;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Read-owner tag: next state.
  always_comb begin
    owner_d = OwnNone;
    if (cpu_gnt && !cpu_wren) begin
      owner_d = OwnCpu;
    end else if (io_gnt && !io_wren) begin
      owner_d = OwnIo;
    end
  end

  // Read-owner tag: outputs. Read data is passed through on the valid cycle, held otherwise.
  always_comb begin
    cpu_rvalid = (owner_q == OwnCpu);
    io_rvalid  = (owner_q == OwnIo);
    cpu_q      = cpu_rvalid ? ram_dataOut : cpu_hold_q;
    io_q       = io_rvalid  ? ram_dataOut : io_hold_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      burst_cnt_q <= 4'd0;
      cpu_hold_q  <= '0;
      io_hold_q   <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      if (cpu_rvalid) begin
        cpu_hold_q <= ram_dataOut;
      end
      if (io_rvalid) begin
        io_hold_q <= ram_dataOut;
      end
    end
  end

  a_one_grant : assert property (@(posedge clock) disable iff (!reset) !(cpu_gnt && io_gnt));
  a_burst_max : assert property (@(posedge clock) disable iff (!reset) burst_cnt_q <= MaxBurst);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed vector table plus multi-cycle corner sequences and a scoreboarded random run.
module tb_dmem_arbiter;

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 32;
  localparam int unsigned MAX = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req = 1'b0, cpu_wren = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_data = '0;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_q;
  logic          io_req = 1'b0, io_wren = 1'b0;
  logic [AW-1:0] io_addr = '0;
  logic [DW-1:0] io_data = '0;
  logic          io_gnt, io_rvalid;
  logic [DW-1:0] io_q;
  logic          ram_wEn;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dataIn;
  logic [DW-1:0] ram_dataOut = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks   = 0;
  int failures = 0;

  dmem_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .MAX_CPU_BURST(MAX)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_wren   (cpu_wren),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_q      (cpu_q),
    .io_req     (io_req),
    .io_wren    (io_wren),
    .io_addr    (io_addr),
    .io_data    (io_data),
    .io_gnt     (io_gnt),
    .io_rvalid  (io_rvalid),
    .io_q       (io_q),
    .ram_wEn    (ram_wEn),
    .ram_addr   (ram_addr),
    .ram_dataIn (ram_dataIn),
    .ram_dataOut(ram_dataOut)
  );

  always #5 clock = ~clock;

  // Synchronous-read RAM, read-before-write.
  always @(posedge clock) begin
    if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= mem[ram_addr];
  end

  typedef struct packed {
    logic          cr, cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          ir, iw;
    logic [AW-1:0] ia;
    logic [DW-1:0] id;
    logic          ecg, eig, ewen;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edata;
    logic          ecrv;
    logic [DW-1:0] ecq;
    logic          eirv;
    logic [DW-1:0] eiq;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vec [NVEC];

  logic pcg = 1'b0, pig = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input logic ir, input logic iw,
                       input logic [AW-1:0] ia, input logic [DW-1:0] id);
    cpu_req = cr; cpu_wren = cw; cpu_addr = ca; cpu_data = cd;
    io_req  = ir; io_wren  = iw; io_addr  = ia; io_data  = id;
  endtask

  // Both ports read; cpu_req always high, io_req and expected io_gnt given as per-cycle bit masks.
  task automatic run_contest(input int n, input logic [31:0] irmask, input logic [31:0] expio);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      drive(1'b1, 1'b0, 12'h010, '0, irmask[i], 1'b0, 12'h002, '0);
      #1;
      chk($sformatf("contest%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'(pcg));
      chk($sformatf("contest%0d io_rvalid", i), 32'(io_rvalid), 32'(pig));
      if (pcg) chk($sformatf("contest%0d cpu_q", i), cpu_q, 32'hDEADBEEF);
      if (pig) chk($sformatf("contest%0d io_q", i), io_q, 32'hBBBB0002);
      chk($sformatf("contest%0d io_gnt", i), 32'(io_gnt), 32'(expio[i]));
      chk($sformatf("contest%0d cpu_gnt", i), 32'(cpu_gnt), 32'(!expio[i]));
      pcg = !expio[i];
      pig = expio[i];
    end
  endtask

  task automatic idle_check(input string name);
    @(negedge clock);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    #1;
    chk({name, " cpu_rvalid"}, 32'(cpu_rvalid), 32'(pcg));
    chk({name, " io_rvalid"}, 32'(io_rvalid), 32'(pig));
    chk({name, " ram_wEn"}, 32'(ram_wEn), 32'd0);
    pcg = 1'b0;
    pig = 1'b0;
  endtask

  logic [DW-1:0] sb [16];
  logic          c_rv, i_rv, c_gl, i_gl;
  logic [DW-1:0] c_exp, i_exp, c_last, i_last;
  int            io_wait;

  initial begin
    //           cr cw ca      cd            ir iw ia      id            cg ig we addr    data          crv cq            irv iq
    vec[0]  = '{0, 0, 12'h055, 32'h00000011, 0, 0, 12'h000, 32'h0,       0, 0, 0, 12'h055, 32'h00000011, 0, 32'h0,        0, 32'h0};
    vec[1]  = '{1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 12'h000, 32'h0,       1, 0, 1, 12'h010, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0};
    vec[2]  = '{1, 1, 12'h001, 32'hAAAA0001, 0, 0, 12'h000, 32'h0,       1, 0, 1, 12'h001, 32'hAAAA0001, 0, 32'h0,        0, 32'h0};
    vec[3]  = '{0, 0, 12'h000, 32'h0,        1, 1, 12'h002, 32'hBBBB0002, 0, 1, 1, 12'h002, 32'hBBBB0002, 0, 32'h0,        0, 32'h0};
    vec[4]  = '{1, 0, 12'h010, 32'h0,        0, 0, 12'h000, 32'h0,       1, 0, 0, 12'h010, 32'h0,        0, 32'h0,        0, 32'h0};
    vec[5]  = '{0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 32'h0,       0, 0, 0, 12'h000, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0};
    vec[6]  = '{0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 32'h0,       0, 0, 0, 12'h000, 32'h0,        0, 32'hDEADBEEF, 0, 32'h0};
    vec[7]  = '{0, 0, 12'h000, 32'h0,        1, 1, 12'hFFF, 32'h12345678, 0, 1, 1, 12'hFFF, 32'h12345678, 0, 32'hDEADBEEF, 0, 32'h0};
    vec[8]  = '{0, 0, 12'h000, 32'h0,        1, 0, 12'hFFF, 32'h0,       0, 1, 0, 12'hFFF, 32'h0,        0, 32'hDEADBEEF, 0, 32'h0};
    vec[9]  = '{0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 32'h0,       0, 0, 0, 12'h000, 32'h0,        0, 32'hDEADBEEF, 1, 32'h12345678};
    vec[10] = '{1, 0, 12'h001, 32'h0,        0, 0, 12'h000, 32'h0,       1, 0, 0, 12'h001, 32'h0,        0, 32'hDEADBEEF, 0, 32'h12345678};
    vec[11] = '{0, 0, 12'h000, 32'h0,        1, 0, 12'h002, 32'h0,       0, 1, 0, 12'h002, 32'h0,        1, 32'hAAAA0001, 0, 32'h12345678};
    vec[12] = '{1, 0, 12'h001, 32'h0,        0, 0, 12'h000, 32'h0,       1, 0, 0, 12'h001, 32'h0,        0, 32'hAAAA0001, 1, 32'hBBBB0002};
    vec[13] = '{0, 0, 12'h000, 32'h0,        1, 0, 12'h002, 32'h0,       0, 1, 0, 12'h002, 32'h0,        1, 32'hAAAA0001, 0, 32'hBBBB0002};
    vec[14] = '{0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 32'h0,       0, 0, 0, 12'h000, 32'h0,        0, 32'hAAAA0001, 1, 32'hBBBB0002};

    // Reset state with requests present: nothing may be granted.
    drive(1'b1, 1'b1, 12'h123, 32'h55, 1'b1, 1'b1, 12'h321, 32'h66);
    #1;
    chk("rst cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("rst io_gnt", 32'(io_gnt), 32'd0);
    chk("rst ram_wEn", 32'(ram_wEn), 32'd0);
    chk("rst cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst io_rvalid", 32'(io_rvalid), 32'd0);
    chk("rst cpu_q", cpu_q, 32'd0);
    chk("rst io_q", io_q, 32'd0);
    repeat (2) @(negedge clock);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clock);
      drive(vec[i].cr, vec[i].cw, vec[i].ca, vec[i].cd, vec[i].ir, vec[i].iw, vec[i].ia, vec[i].id);
      #1;
      chk($sformatf("vec%0d cpu_gnt", i), 32'(cpu_gnt), 32'(vec[i].ecg));
      chk($sformatf("vec%0d io_gnt", i), 32'(io_gnt), 32'(vec[i].eig));
      chk($sformatf("vec%0d ram_wEn", i), 32'(ram_wEn), 32'(vec[i].ewen));
      chk($sformatf("vec%0d ram_addr", i), 32'(ram_addr), 32'(vec[i].eaddr));
      chk($sformatf("vec%0d ram_dataIn", i), ram_dataIn, vec[i].edata);
      chk($sformatf("vec%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'(vec[i].ecrv));
      chk($sformatf("vec%0d cpu_q", i), cpu_q, vec[i].ecq);
      chk($sformatf("vec%0d io_rvalid", i), 32'(io_rvalid), 32'(vec[i].eirv));
      chk($sformatf("vec%0d io_q", i), io_q, vec[i].eiq);
    end

    // 12 contested cycles: C,C,C,C,I,C,C,C,C,I,C,C.
    run_contest(12, 32'h00000FFF, 32'h00000210);
    idle_check("post_contest");
    // I/O drops its request mid-burst; the burst count restarts from zero.
    run_contest(8, 32'h000000FB, 32'h00000080);
    idle_check("post_drop");

    // Reset asserted with a CPU read outstanding.
    @(negedge clock);
    drive(1'b1, 1'b0, 12'h010, '0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("rdrst cpu_gnt", 32'(cpu_gnt), 32'd1);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("rdrst cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rdrst cpu_q", cpu_q, 32'd0);
    chk("rdrst io_q", io_q, 32'd0);
    chk("rdrst cpu_gnt held", 32'(cpu_gnt), 32'd0);
    chk("rdrst ram_wEn", 32'(ram_wEn), 32'd0);
    @(negedge clock);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    #1;
    chk("rel ram_wEn", 32'(ram_wEn), 32'd0);
    chk("rel cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    idle_check("rel2");

    // Known contents for the random window.
    for (int a = 0; a < 16; a++) begin
      @(negedge clock);
      sb[a] = 32'hC0DE0000 ^ (32'(a) * 32'h01010101);
      drive(1'b1, 1'b1, 12'(a), sb[a], 1'b0, 1'b0, '0, '0);
      #1;
      chk($sformatf("fill%0d cpu_gnt", a), 32'(cpu_gnt), 32'd1);
    end

    c_rv = 1'b0; i_rv = 1'b0; c_gl = 1'b1; i_gl = 1'b1;
    c_exp = '0; i_exp = '0; c_last = '0; i_last = '0;
    io_wait = 0;
    cpu_req = 1'b0; io_req = 1'b0;
    for (int t = 0; t < 10000; t++) begin
      @(negedge clock);
      if (!cpu_req || c_gl) begin
        cpu_req  = ($urandom_range(0, 9) < 6);
        cpu_wren = 1'($urandom_range(0, 1));
        cpu_addr = 12'($urandom_range(0, 15));
        cpu_data = $urandom;
      end
      if (!io_req || i_gl) begin
        io_req  = ($urandom_range(0, 9) < 6);
        io_wren = 1'($urandom_range(0, 1));
        io_addr = 12'($urandom_range(0, 15));
        io_data = $urandom;
      end
      #1;
      chk("rnd cpu_rvalid", 32'(cpu_rvalid), 32'(c_rv));
      chk("rnd io_rvalid", 32'(io_rvalid), 32'(i_rv));
      if (c_rv) c_last = c_exp;
      if (i_rv) i_last = i_exp;
      chk("rnd cpu_q", cpu_q, c_last);
      chk("rnd io_q", io_q, i_last);
      chk("rnd both_gnt", 32'(cpu_gnt & io_gnt), 32'd0);
      if (cpu_req && !io_req) chk("rnd cpu_only", 32'(cpu_gnt), 32'd1);
      if (io_req && !cpu_req) chk("rnd io_only", 32'(io_gnt), 32'd1);
      if (cpu_req && io_req) chk("rnd contest", 32'(cpu_gnt | io_gnt), 32'd1);
      if (!cpu_req && !io_req) chk("rnd idle_wen", 32'(ram_wEn), 32'd0);
      if (io_req && !io_gnt) io_wait++;
      else io_wait = 0;
      if (io_req) chk("rnd io_wait_ok", 32'(io_wait <= MAX), 32'd1);
      c_rv = 1'b0;
      i_rv = 1'b0;
      if (cpu_gnt) begin
        chk("rnd cpu ram_addr", 32'(ram_addr), 32'(cpu_addr));
        chk("rnd cpu ram_wEn", 32'(ram_wEn), 32'(cpu_wren));
        if (cpu_wren) begin
          chk("rnd cpu ram_dataIn", ram_dataIn, cpu_data);
          sb[cpu_addr[3:0]] = cpu_data;
        end else begin
          c_rv  = 1'b1;
          c_exp = sb[cpu_addr[3:0]];
        end
      end
      if (io_gnt) begin
        chk("rnd io ram_addr", 32'(ram_addr), 32'(io_addr));
        chk("rnd io ram_wEn", 32'(ram_wEn), 32'(io_wren));
        if (io_wren) begin
          chk("rnd io ram_dataIn", ram_dataIn, io_data);
          sb[io_addr[3:0]] = io_data;
        end else begin
          i_rv  = 1'b1;
          i_exp = sb[io_addr[3:0]];
        end
      end
      c_gl = cpu_gnt;
      i_gl = io_gnt;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, giving the RAM word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the RAM data width.
REQ-003 The block SHALL have parameter MAX_CPU_BURST, default 4, giving the maximum consecutive contested CPU grants before the I/O port is served (legal range 1..15).
REQ-004 Port list SHALL be as follows (name, direction, width, meaning):
- clock  in  1  single clock for all state.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until granted.
- cpu_wren  in  1  CPU write (1) / read (0).
- cpu_addr  in  ADDR_WIDTH  CPU word address.
- cpu_data  in  DATA_WIDTH  CPU write data.
- cpu_gnt  out  1  CPU access issued to RAM this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_q  out  DATA_WIDTH  CPU read data.
- io_req, io_wren, io_addr, io_data, io_gnt, io_rvalid, io_q: same as the cpu_* ports, for the I/O requester.
- ram_wEn  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_dataIn  out  DATA_WIDTH  RAM write data.
- ram_dataOut  in  DATA_WIDTH  RAM read data, valid one cycle after the address is presented (synchronous read).

Function
REQ-005 The block SHALL issue at most one RAM access per cycle and SHALL assert at most one of cpu_gnt or io_gnt in any cycle.
REQ-006 Grant SHALL be combinational from the current requests and registered state; the granted port's addr, data, and wren SHALL drive ram_addr, ram_dataIn, and ram_wEn in the same cycle.
REQ-007 Uncontested requests: if only one req is high, that port SHALL be granted.
REQ-008 Contested requests (both high): CPU SHALL be granted unless burst_cnt == MAX_CPU_BURST, in which case I/O SHALL be granted.
REQ-009 burst_cnt (4-bit) SHALL increment on each contested cycle granted to CPU, SHALL clear when io_gnt is asserted or io_req is low, and SHALL never exceed MAX_CPU_BURST.
REQ-010 Idle (no req): ram_wEn SHALL be 0, ram_addr SHALL equal cpu_addr, ram_dataIn SHALL equal cpu_data, and both gnt outputs SHALL be 0.
REQ-011 ram_wEn SHALL be 1 only in a cycle where the granted port's wren is 1.
REQ-012 A granted read SHALL set a registered owner tag (NONE/CPU/IO); in the next cycle the owner's rvalid SHALL be 1 for exactly one cycle, and that port's q SHALL equal ram_dataOut.
REQ-013 Granted writes SHALL produce no rvalid.
REQ-014 cpu_q and io_q SHALL each hold their last delivered value when not valid, using a per-port hold register loaded on that port's rvalid cycle.
REQ-015 Back-to-back reads SHALL sustain one access per cycle, with rvalid following each grant by exactly one cycle, including alternating owners.
REQ-016 A request dropped before grant SHALL be ignored without error; the requester SHALL be considered non-compliant, but the block's state SHALL be unaffected.

Reset
REQ-017 While reset = 0, the following SHALL be 0: cpu_gnt, io_gnt, cpu_rvalid, io_rvalid, ram_wEn, cpu_q, io_q, burst_cnt; the owner tag SHALL be NONE.
REQ-018 Reset asserted with a read outstanding SHALL suppress that read's rvalid; after release, no stale rvalid SHALL appear.
REQ-019 The first grant after reset release SHALL occur no earlier than the first rising clock edge with reset = 1 and a request present.

Verification
REQ-020 CPU-only read, addr 0x010, RAM holding 0xDEADBEEF -> cpu_gnt=1 at cycle N; cpu_rvalid=1 and cpu_q=0xDEADBEEF at N+1; io outputs stay 0.
REQ-021 I/O-only write, addr 0xFFF, data 0x12345678 -> io_gnt=1 and ram_wEn=1 at ram_addr 0xFFF; a subsequent I/O read of 0xFFF returns 0x12345678.
REQ-022 Both ports hold req for 12 cycles (MAX_CPU_BURST=4) -> grant pattern C,C,C,C,I repeating; no I/O wait exceeds 4 cycles.
REQ-023 Alternating CPU read 0x001 / I/O read 0x002 on consecutive cycles -> each rvalid one cycle after its own grant, with the correct data per owner and no cross-delivery.
REQ-024 reset driven low in the cycle after a CPU read grant -> cpu_rvalid stays 0 and cpu_q=0; after release, an idle bus shows ram_wEn=0.
REQ-025 Random traffic against a scoreboard RAM model for 10k cycles -> never both gnt high, every read returns the last written value, and no I/O wait exceeds MAX_CPU_BURST cycles.
